// File: rtl/time_pkg.sv
// Shared types, field limits and helpers for the time-setting controller.
package time_pkg;

  localparam int unsigned HOUR_W  = 5;
  localparam int unsigned MS_W    = 6;
  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SET_HOUR = 3'd1,
    SET_MIN  = 3'd2,
    SET_SEC  = 3'd3,
    COMMIT   = 3'd4
  } set_state_t;

  typedef logic [1:0] field_sel_t;

  localparam field_sel_t FIELD_NONE   = 2'd0;
  localparam field_sel_t FIELD_HOUR   = 2'd1;
  localparam field_sel_t FIELD_MINUTE = 2'd2;
  localparam field_sel_t FIELD_SECOND = 2'd3;

  // Time payload carried by the shadows and the load bus.
  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MS_W-1:0]   minute;
    logic [MS_W-1:0]   second;
  } time_val_t;

  // Increment that wraps to zero past the field's top value.
  function automatic logic [MS_W-1:0] wrap_inc(input logic [MS_W-1:0] value,
                                               input logic [MS_W-1:0] top);
    return (value >= top) ? '0 : value + MS_W'(1);
  endfunction

  // Out-of-range live values are captured as zero so a shadow stays in range.
  function automatic logic [MS_W-1:0] clamp_field(input logic [MS_W-1:0] value,
                                                  input logic [MS_W-1:0] top);
    return (value > top) ? '0 : value;
  endfunction

endpackage

// File: rtl/time_set_controller_set_idle_timer.sv
// Idle timer: counts 1 Hz ticks since the last button, flags expiry on the
// tick that reaches LIMIT. A clear in the same cycle suppresses expiry.
module set_idle_timer #(
  parameter int unsigned LIMIT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expire_c
);

  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  assign expire_c = tick && !clear && (count == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || expire_c) begin
      count <= '0;
    end else if (tick) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/time_set_controller.sv
// Walks hour/minute/second edit fields from button pulses and issues a
// one-cycle load to the time counters. Optional blink: TIME_SET_BLINK_EN.
module time_set_controller
  import time_pkg::*;
#(
  parameter int unsigned TIMEOUT_S = 10,
  parameter int unsigned HOUR_MAX  = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_1hz,
  input  logic              mode_btn,
  input  logic              inc_btn,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MS_W-1:0]   cur_minute,
  input  logic [MS_W-1:0]   cur_second,
  output logic              set_time_en,
  output logic [HOUR_W-1:0] set_time_hour,
  output logic [MS_W-1:0]   set_time_minute,
  output logic [MS_W-1:0]   set_time_second,
  output logic              edit_active,
  output field_sel_t        field_sel,
  output logic              blink
);

  localparam logic [MS_W-1:0] HOUR_TOP = MS_W'(HOUR_MAX);
  localparam logic [MS_W-1:0] MIN_TOP  = MS_W'(MIN_MAX);
  localparam logic [MS_W-1:0] SEC_TOP  = MS_W'(SEC_MAX);

  set_state_t state, state_d;
  time_val_t  shadow_q, shadow_d;
  time_val_t  load_d;
  logic       load_en_d;
  logic       edit_d;
  field_sel_t field_d;

  logic in_set_c;
  logic inc_eff_c;
  logic timer_clear_c;
  logic timer_tick_c;
  logic expire_c;

  assign in_set_c      = (state == SET_HOUR) || (state == SET_MIN) || (state == SET_SEC);
  assign inc_eff_c     = inc_btn && !mode_btn;
  assign timer_clear_c = mode_btn || inc_btn || !in_set_c;
  assign timer_tick_c  = tick_1hz && in_set_c;

  set_idle_timer #(
    .LIMIT (TIMEOUT_S)
  ) u_idle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (timer_clear_c),
    .tick     (timer_tick_c),
    .expire_c (expire_c)
  );

  // Next state, shadow updates and next registered outputs.
  always_comb begin
    state_d   = state;
    shadow_d  = shadow_q;
    load_d    = '{hour: set_time_hour, minute: set_time_minute, second: set_time_second};
    load_en_d = 1'b0;
    edit_d    = 1'b0;
    field_d   = FIELD_NONE;

    case (state)
      RUN: begin
        if (mode_btn) begin
          shadow_d.hour   = HOUR_W'(clamp_field(MS_W'(cur_hour), HOUR_TOP));
          shadow_d.minute = clamp_field(cur_minute, MIN_TOP);
          shadow_d.second = clamp_field(cur_second, SEC_TOP);
          state_d         = SET_HOUR;
        end
      end
      SET_HOUR: begin
        if (mode_btn) begin
          state_d = SET_MIN;
        end else if (inc_eff_c) begin
          shadow_d.hour = HOUR_W'(wrap_inc(MS_W'(shadow_q.hour), HOUR_TOP));
        end else if (expire_c) begin
          state_d  = RUN;
          shadow_d = '0;
        end
      end
      SET_MIN: begin
        if (mode_btn) begin
          state_d = SET_SEC;
        end else if (inc_eff_c) begin
          shadow_d.minute = wrap_inc(shadow_q.minute, MIN_TOP);
        end else if (expire_c) begin
          state_d  = RUN;
          shadow_d = '0;
        end
      end
      SET_SEC: begin
        if (mode_btn) begin
          state_d = COMMIT;
        end else if (inc_eff_c) begin
          shadow_d.second = wrap_inc(shadow_q.second, SEC_TOP);
        end else if (expire_c) begin
          state_d  = RUN;
          shadow_d = '0;
        end
      end
      COMMIT:  state_d = RUN;
      default: state_d = RUN;
    endcase

    // Outputs are registered from the next state so they align with it.
    load_en_d = (state_d == COMMIT);
    if (load_en_d) begin
      load_d = shadow_d;
    end
    edit_d = (state_d != RUN);
    case (state_d)
      SET_HOUR: field_d = FIELD_HOUR;
      SET_MIN:  field_d = FIELD_MINUTE;
      SET_SEC:  field_d = FIELD_SECOND;
      default:  field_d = FIELD_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= RUN;
      shadow_q        <= '0;
      set_time_en     <= 1'b0;
      set_time_hour   <= '0;
      set_time_minute <= '0;
      set_time_second <= '0;
      edit_active     <= 1'b0;
      field_sel       <= FIELD_NONE;
    end else begin
      state           <= state_d;
      shadow_q        <= shadow_d;
      set_time_en     <= load_en_d;
      set_time_hour   <= load_d.hour;
      set_time_minute <= load_d.minute;
      set_time_second <= load_d.second;
      edit_active     <= edit_d;
      field_sel       <= field_d;
    end
  end

`ifdef TIME_SET_BLINK_EN
  logic blink_d;

  // Toggle per tick while editing; an increment keeps the digit visible.
  always_comb begin
    blink_d = blink;
    if (!((state_d == SET_HOUR) || (state_d == SET_MIN) || (state_d == SET_SEC))) begin
      blink_d = 1'b0;
    end else if (in_set_c && inc_eff_c) begin
      blink_d = 1'b0;
    end else if (in_set_c && tick_1hz) begin
      blink_d = ~blink;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink <= 1'b0;
    end else begin
      blink <= blink_d;
    end
  end
`else
  assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_time_set_controller.sv
// Self-checking bench for time_set_controller: directed scenarios plus
// randomized stimulus, all compared every cycle against a behavioural model.
module tb_time_set_controller;

  localparam int TIMEOUT = 10;
  localparam int HMAX    = 23;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1hz, mode_btn, inc_btn;
  logic [4:0] cur_hour;
  logic [5:0] cur_minute, cur_second;
  logic       set_time_en;
  logic [4:0] set_time_hour;
  logic [5:0] set_time_minute, set_time_second;
  logic       edit_active;
  logic [1:0] field_sel;
  logic       blink;

  always #5 clk = ~clk;

  time_set_controller #(.TIMEOUT_S(TIMEOUT), .HOUR_MAX(HMAX)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tick_1hz        (tick_1hz),
    .mode_btn        (mode_btn),
    .inc_btn         (inc_btn),
    .cur_hour        (cur_hour),
    .cur_minute      (cur_minute),
    .cur_second      (cur_second),
    .set_time_en     (set_time_en),
    .set_time_hour   (set_time_hour),
    .set_time_minute (set_time_minute),
    .set_time_second (set_time_second),
    .edit_active     (edit_active),
    .field_sel       (field_sel),
    .blink           (blink)
  );

`ifdef TIME_SET_BLINK_EN
  localparam int BLINK_ON = 1;
`else
  localparam int BLINK_ON = 0;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int pulses  = 0;

  // Model: phase 0 = not editing, 1..3 = editing hour/minute/second, 4 = loading.
  int phase = 0;
  int sh_h = 0, sh_m = 0, sh_s = 0;
  int idle = 0;
  int mblink = 0;
  int e_en = 0, e_h = 0, e_m = 0, e_s = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_step(input int r, input int t, input int m, input int i,
                            input int ch, input int cm, input int cs);
    int  old;
    bit  was_set;
    if (r == 0) begin
      phase = 0; sh_h = 0; sh_m = 0; sh_s = 0; idle = 0; mblink = 0;
      e_en = 0; e_h = 0; e_m = 0; e_s = 0;
      return;
    end
    old     = phase;
    was_set = (old >= 1 && old <= 3);
    if (old == 0) begin
      if (m != 0) begin
        sh_h = ch; sh_m = cm; sh_s = cs; phase = 1; idle = 0;
      end
    end else if (was_set) begin
      if (m != 0) begin
        phase = old + 1; idle = 0;
      end else if (i != 0) begin
        if (old == 1) sh_h = (sh_h + 1) % (HMAX + 1);
        else if (old == 2) sh_m = (sh_m + 1) % 60;
        else sh_s = (sh_s + 1) % 60;
        idle = 0;
      end else if (t != 0) begin
        idle++;
        if (idle >= TIMEOUT) begin
          phase = 0; idle = 0;
        end
      end
    end else begin
      phase = 0;
    end
    e_en = (phase == 4) ? 1 : 0;
    if (e_en != 0) begin
      e_h = sh_h; e_m = sh_m; e_s = sh_s;
    end
    if (BLINK_ON == 0 || !(phase >= 1 && phase <= 3)) mblink = 0;
    else if (was_set && i != 0 && m == 0) mblink = 0;
    else if (was_set && t != 0) mblink = 1 - mblink;
  endtask

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    model_step(int'(rst_n), int'(tick_1hz), int'(mode_btn), int'(inc_btn),
               int'(cur_hour), int'(cur_minute), int'(cur_second));
    #1;
    if (set_time_en) pulses++;
    check("set_time_en", int'(set_time_en), e_en);
    check("set_time_hour", int'(set_time_hour), e_h);
    check("set_time_minute", int'(set_time_minute), e_m);
    check("set_time_second", int'(set_time_second), e_s);
    check("edit_active", int'(edit_active), (phase != 0) ? 1 : 0);
    check("field_sel", int'(field_sel), (phase >= 1 && phase <= 3) ? phase : 0);
    check("blink", int'(blink), mblink);
  end

  task automatic cyc(input bit m, input bit i, input bit t);
    mode_btn = m; inc_btn = i; tick_1hz = t;
    @(negedge clk);
  endtask

  task automatic set_cur(input int h, input int mi, input int s);
    cur_hour = 5'(h); cur_minute = 6'(mi); cur_second = 6'(s);
  endtask

  initial begin
    int p0;
    int tdiv, mdiv, idiv;
    rst_n = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0; tick_1hz = 1'b0;
    set_cur(0, 0, 0);
    @(negedge clk);
    cyc(0, 0, 0);
    check("reset_en", int'(set_time_en), 0);
    check("reset_edit", int'(edit_active), 0);
    check("reset_field", int'(field_sel), 0);
    check("reset_hour", int'(set_time_hour), 0);
    rst_n = 1'b1;
    cyc(0, 0, 0);

    // Full set sequence 12:34:56 -> 15:35:56.
    set_cur(12, 34, 56);
    cyc(1, 0, 0);
    repeat (3) cyc(0, 1, 0);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    p0 = pulses;
    cyc(1, 0, 0);
    check("full_en", int'(set_time_en), 1);
    check("full_hour", int'(set_time_hour), 15);
    check("full_minute", int'(set_time_minute), 35);
    check("full_second", int'(set_time_second), 56);
    check("full_pulses", pulses - p0, 1);
    cyc(0, 0, 0);
    check("full_edit_drop", int'(edit_active), 0);
    check("full_en_drop", int'(set_time_en), 0);
    check("full_hold_hour", int'(set_time_hour), 15);

    // Reset mid-edit discards everything.
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    p0 = pulses;
    rst_n = 1'b0;
    cyc(0, 0, 0);
    rst_n = 1'b1;
    check("rst_edit", int'(edit_active), 0);
    check("rst_field", int'(field_sel), 0);
    check("rst_hour", int'(set_time_hour), 0);
    cyc(0, 0, 0);
    check("rst_no_load", pulses - p0, 0);

    // Wrap of every field.
    set_cur(23, 59, 58);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    check("wrap_en", int'(set_time_en), 1);
    check("wrap_hour", int'(set_time_hour), 0);
    check("wrap_minute", int'(set_time_minute), 0);
    check("wrap_second", int'(set_time_second), 0);
    cyc(0, 0, 0);

    // Timeout in SET_MIN.
    set_cur(7, 8, 9);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    p0 = pulses;
    repeat (TIMEOUT - 1) cyc(0, 0, 1);
    check("to_before", int'(field_sel), 2);
    cyc(0, 0, 1);
    check("to_edit", int'(edit_active), 0);
    check("to_field", int'(field_sel), 0);
    check("to_no_load", pulses - p0, 0);

    // An inc on the 9th tick restarts the idle count.
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    repeat (TIMEOUT - 2) cyc(0, 0, 1);
    cyc(0, 1, 1);
    check("to_inc_hold", int'(field_sel), 2);
    repeat (TIMEOUT - 1) cyc(0, 0, 1);
    check("to_restart", int'(field_sel), 2);
    cyc(0, 0, 1);
    check("to_restart_exp", int'(field_sel), 0);

    // Mode and inc together: mode wins.
    set_cur(5, 6, 7);
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    check("sim_field", int'(field_sel), 2);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    check("sim_en", int'(set_time_en), 1);
    check("sim_hour", int'(set_time_hour), 5);
    check("sim_minute", int'(set_time_minute), 6);
    cyc(0, 0, 0);

    // Blink in SET_SEC.
    set_cur(1, 2, 3);
    repeat (3) cyc(1, 0, 0);
    check("blink0", int'(blink), 0);
    cyc(0, 0, 1);
    check("blink1", int'(blink), BLINK_ON);
    cyc(0, 0, 1);
    check("blink2", int'(blink), 0);
    cyc(0, 0, 1);
    check("blink3", int'(blink), BLINK_ON);
    cyc(0, 1, 1);
    check("blink_inc", int'(blink), 0);
    cyc(0, 0, 1);
    check("blink4", int'(blink), BLINK_ON);
    cyc(1, 0, 0);
    check("blink_leave", int'(blink), 0);
    cyc(0, 0, 0);

    // Randomized segments with varying button and tick densities.
    for (int seg = 0; seg < 9; seg++) begin
      tdiv = (seg % 3 == 0) ? 1 : ((seg % 3 == 1) ? 2 : 4);
      mdiv = (seg < 3) ? 6 : ((seg < 6) ? 40 : 150);
      idiv = (seg < 3) ? 3 : ((seg < 6) ? 20 : 150);
      for (int n = 0; n < 500; n++) begin
        set_cur(int'($urandom_range(0, HMAX)), int'($urandom_range(0, 59)),
                int'($urandom_range(0, 59)));
        rst_n = ($urandom_range(0, 399) != 0);
        cyc($urandom_range(0, mdiv - 1) == 0, $urandom_range(0, idiv - 1) == 0,
            $urandom_range(0, tdiv - 1) == 0);
      end
    end
    rst_n = 1'b1;
    repeat (3) cyc(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
